// File: rtl/inst_fetch_bridge_if.sv
// Fetch-side and instruction-memory-side signals of the instruction fetch bridge.
// The bridge uses the slave view; the IF stage and memory (or a bench) use master.
interface inst_fetch_bridge_if;
    // IF stage side
    logic [31:0] pc_i;
    logic        pc_valid_i;
    logic        pc_ready_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic        flush_i;
    // memory side
    logic        inst_req_o;
    logic [31:0] inst_addr_o;
    logic        inst_addr_ok_i;
    logic        inst_data_ok_i;
    logic [31:0] inst_rdata_i;

    modport slave (
        input  pc_i, pc_valid_i, inst_ready_i, flush_i,
               inst_addr_ok_i, inst_data_ok_i, inst_rdata_i,
        output pc_ready_o, inst_o, inst_pc_o, inst_valid_o,
               inst_req_o, inst_addr_o
    );

    modport master (
        output pc_i, pc_valid_i, inst_ready_i, flush_i,
               inst_addr_ok_i, inst_data_ok_i, inst_rdata_i,
        input  pc_ready_o, inst_o, inst_pc_o, inst_valid_o,
               inst_req_o, inst_addr_o
    );
endinterface

// File: rtl/inst_fetch_bridge.sv
// Bridges IF-stage fetch requests onto a split address/data instruction bus, keeping at
// most two fetches in flight or buffered, and dropping responses orphaned by a flush.
module inst_fetch_bridge (
    input  logic                  clk,
    input  logic                  resetn,
    inst_fetch_bridge_if.slave    bus
);

    logic [1:0]  pend_cnt;
    logic [1:0]  drop_cnt;
    logic [1:0]  resp_cnt;
    logic [1:0]  pend_nxt;

    logic [31:0] pc_fifo [2];
    logic        pc_wptr;
    logic        pc_rptr;

    logic [31:0] resp_pc   [2];
    logic [31:0] resp_inst [2];
    logic        resp_wptr;
    logic        resp_rptr;

    logic        credit;
    logic        req;
    logic        addr_hs;
    logic        data_acc;
    logic        data_keep;
    logic        data_drop;
    logic        vld;
    logic        head_pop;

    // Buffered responses count against credit so the response FIFO can never overflow.
    assign credit    = ({1'b0, pend_cnt} + {1'b0, resp_cnt}) < 3'd2;
    assign req       = bus.pc_valid_i & credit & ~bus.flush_i;
    assign addr_hs   = req & bus.inst_addr_ok_i;

    assign data_acc  = bus.inst_data_ok_i & (pend_cnt != 2'd0);
    assign data_keep = data_acc & (drop_cnt == 2'd0);
    assign data_drop = data_acc & (drop_cnt != 2'd0);

    assign vld       = (resp_cnt != 2'd0) & ~bus.flush_i;
    assign head_pop  = vld & bus.inst_ready_i;

    assign pend_nxt  = pend_cnt + {1'b0, addr_hs} - {1'b0, data_acc};

    assign bus.inst_req_o   = req;
    assign bus.inst_addr_o  = bus.pc_i;
    assign bus.pc_ready_o   = addr_hs;
    assign bus.inst_valid_o = vld;
    assign bus.inst_o       = vld ? resp_inst[resp_rptr] : 32'h0;
    assign bus.inst_pc_o    = vld ? resp_pc[resp_rptr]   : 32'h0;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pend_cnt  <= 2'd0;
            drop_cnt  <= 2'd0;
            resp_cnt  <= 2'd0;
            pc_wptr   <= 1'b0;
            pc_rptr   <= 1'b0;
            resp_wptr <= 1'b0;
            resp_rptr <= 1'b0;
        end else begin
            pend_cnt <= pend_nxt;
            if (addr_hs)
                pc_wptr <= ~pc_wptr;
            if (data_acc)
                pc_rptr <= ~pc_rptr;
            if (bus.flush_i) begin
                // Anything still outstanding after this cycle's return belongs to the old stream.
                drop_cnt  <= pend_nxt;
                resp_cnt  <= 2'd0;
                resp_wptr <= 1'b0;
                resp_rptr <= 1'b0;
            end else begin
                drop_cnt <= drop_cnt - {1'b0, data_drop};
                resp_cnt <= resp_cnt + {1'b0, data_keep} - {1'b0, head_pop};
                if (data_keep)
                    resp_wptr <= ~resp_wptr;
                if (head_pop)
                    resp_rptr <= ~resp_rptr;
            end
        end
    end

    // Payload storage needs no reset; occupancy and pointers qualify it.
    always_ff @(posedge clk) begin
        if (addr_hs)
            pc_fifo[pc_wptr] <= bus.pc_i;
        if (data_keep && !bus.flush_i) begin
            resp_pc[resp_wptr]   <= pc_fifo[pc_rptr];
            resp_inst[resp_wptr] <= bus.inst_rdata_i;
        end
    end

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Bench for inst_fetch_bridge: queue-based reference model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic including flush and reset.
module tb_inst_fetch_bridge;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    inst_fetch_bridge_if bus();

    inst_fetch_bridge dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit cmp_en = 1'b0;

    typedef struct { logic [31:0] pc; bit drop; }             pend_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; }    resp_t;

    pend_t pend[$];
    resp_t resp[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference outputs derived from queue occupancy and current inputs.
    function automatic bit m_credit();
        return (pend.size() + resp.size()) < 2;
    endfunction
    function automatic bit m_req();
        return bus.pc_valid_i && m_credit() && !bus.flush_i;
    endfunction
    function automatic bit m_valid();
        return (resp.size() > 0) && !bus.flush_i;
    endfunction

    always @(posedge clk) begin : model
        pend_t pe;
        bit    hs;
        bit    pop;
        if (!resetn) begin
            pend.delete();
            resp.delete();
        end else begin
            hs  = m_req() && bus.inst_addr_ok_i;
            pop = m_valid() && bus.inst_ready_i;
            if (pop) void'(resp.pop_front());
            if (bus.inst_data_ok_i && pend.size() > 0) begin
                pe = pend.pop_front();
                if (!pe.drop) resp.push_back('{pe.pc, bus.inst_rdata_i});
            end
            if (hs) pend.push_back('{bus.pc_i, 1'b0});
            if (bus.flush_i) begin
                resp.delete();
                foreach (pend[i]) pend[i].drop = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("inst_req_o",   32'(bus.inst_req_o),   32'(m_req()));
            chk("inst_addr_o",  bus.inst_addr_o,       bus.pc_i);
            chk("pc_ready_o",   32'(bus.pc_ready_o),   32'(m_req() && bus.inst_addr_ok_i));
            chk("inst_valid_o", 32'(bus.inst_valid_o), 32'(m_valid()));
            chk("inst_o",       bus.inst_o,            m_valid() ? resp[0].inst : 32'h0);
            chk("inst_pc_o",    bus.inst_pc_o,         m_valid() ? resp[0].pc   : 32'h0);
        end
    end

    // One clock cycle: inputs change just after the rising edge, return just after the falling edge.
    task automatic cyc(input bit pv, input logic [31:0] pc, input bit aok, input bit dok,
                       input logic [31:0] rd, input bit rdy, input bit fl, input bit rn);
        @(posedge clk);
        #2;
        resetn             = rn;
        bus.pc_valid_i     = pv;
        bus.pc_i           = pc;
        bus.inst_addr_ok_i = aok;
        bus.inst_data_ok_i = dok;
        bus.inst_rdata_i   = rd;
        bus.inst_ready_i   = rdy;
        bus.flush_i        = fl;
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input bit rdy);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, rdy, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        repeat (2) cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    logic [31:0] got[$];
    logic [31:0] next_pc;

    initial begin
        bus.pc_valid_i = 1'b0; bus.pc_i = '0; bus.inst_addr_ok_i = 1'b0;
        bus.inst_data_ok_i = 1'b0; bus.inst_rdata_i = '0; bus.inst_ready_i = 1'b0;
        bus.flush_i = 1'b0;
        repeat (2) @(posedge clk);
        cmp_en = 1'b1;

        // Reset state, and single fetch with one-cycle response visibility.
        do_reset();
        cyc(1'b1, 32'hbfc00000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("rst inst_o", bus.inst_o, 32'h0);
        chk("rst inst_pc_o", bus.inst_pc_o, 32'h0);
        chk("t36 req", 32'(bus.inst_req_o), 1);
        chk("t36 hs", 32'(bus.pc_ready_o), 1);
        idle(1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h24080001, 1'b0, 1'b0, 1'b1);
        chk("t36 no bypass", 32'(bus.inst_valid_o), 0);
        idle(1'b1);
        chk("t36 valid", 32'(bus.inst_valid_o), 1);
        chk("t36 inst", bus.inst_o, 32'h24080001);
        chk("t36 pc", bus.inst_pc_o, 32'hbfc00000);
        idle(1'b0);
        chk("t36 popped", 32'(bus.inst_valid_o), 0);

        // Credit limit with data withheld.
        do_reset();
        got.delete();
        next_pc = 32'hbfc00000;
        repeat (5) begin
            cyc(1'b1, next_pc, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
            if (bus.pc_ready_o) begin got.push_back(next_pc); next_pc += 32'd4; end
        end
        chk("t37 hs count", 32'(got.size()), 2);
        chk("t37 hs0", got.size() > 0 ? got[0] : 32'hx, 32'hbfc00000);
        chk("t37 hs1", got.size() > 1 ? got[1] : 32'hx, 32'hbfc00004);
        chk("t37 stalled", 32'(bus.pc_ready_o), 0);
        repeat (2) cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h12345678, 1'b1, 1'b0, 1'b1);
        repeat (2) idle(1'b1);

        // Flush with two outstanding; both responses dropped.
        do_reset();
        cyc(1'b1, 32'hbfc00100, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 32'hbfc00104, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 32'hbfc00108, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        chk("t38 flush no req", 32'(bus.inst_req_o), 0);
        repeat (2) begin
            cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'hdead0000, 1'b1, 1'b0, 1'b1);
            chk("t38 dropped", 32'(bus.inst_valid_o), 0);
        end
        idle(1'b1);
        chk("t38 dropped late", 32'(bus.inst_valid_o), 0);
        cyc(1'b1, 32'hbfc00380, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        chk("t38 new hs", 32'(bus.pc_ready_o), 1);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h3c1abfc0, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        chk("t38 valid", 32'(bus.inst_valid_o), 1);
        chk("t38 pc", bus.inst_pc_o, 32'hbfc00380);
        chk("t38 inst", bus.inst_o, 32'h3c1abfc0);

        // Backpressure with two buffered responses, then in-order drain.
        do_reset();
        cyc(1'b1, 32'h00000200, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 32'h00000204, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h11111111, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h22222222, 1'b0, 1'b0, 1'b1);
        repeat (2) begin
            cyc(1'b1, 32'h00000208, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
            chk("t39 hold valid", 32'(bus.inst_valid_o), 1);
            chk("t39 hold inst", bus.inst_o, 32'h11111111);
            chk("t39 no credit", 32'(bus.pc_ready_o), 0);
        end
        idle(1'b1);
        chk("t39 out0 inst", bus.inst_o, 32'h11111111);
        chk("t39 out0 pc", bus.inst_pc_o, 32'h00000200);
        idle(1'b1);
        chk("t39 out1 inst", bus.inst_o, 32'h22222222);
        chk("t39 out1 pc", bus.inst_pc_o, 32'h00000204);
        idle(1'b1);
        chk("t39 empty", 32'(bus.inst_valid_o), 0);

        // Stray data_ok with nothing pending.
        do_reset();
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'hdeadbeef, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 32'h00000300, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        chk("t40 valid", 32'(bus.inst_valid_o), 0);
        chk("t40 req", 32'(bus.inst_req_o), 1);
        chk("t40 no hs", 32'(bus.pc_ready_o), 0);
        cyc(1'b1, 32'h00000300, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'hcafef00d, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        chk("t40 pc", bus.inst_pc_o, 32'h00000300);
        chk("t40 inst", bus.inst_o, 32'hcafef00d);

        // Reset mid-transaction abandons pending and buffered state.
        do_reset();
        cyc(1'b1, 32'h00000400, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h44444444, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 32'h00000404, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 32'h00000408, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'hbadbad00, 1'b0, 1'b0, 1'b1);
        chk("t41 valid", 32'(bus.inst_valid_o), 0);
        cyc(1'b1, 32'h00000500, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("t41 hs", 32'(bus.pc_ready_o), 1);
        chk("t41 still empty", 32'(bus.inst_valid_o), 0);
        cyc(1'b1, 32'h00000504, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("t41 no aok", 32'(bus.pc_ready_o), 0);
        chk("t41 stale ignored", 32'(bus.inst_valid_o), 0);

        // Randomized traffic; every cycle is checked against the model.
        do_reset();
        repeat (3000) begin
            cyc($urandom_range(99) < 70, {$urandom_range(32'hffff), 2'b00} | 32'hbfc00000,
                $urandom_range(99) < 60, $urandom_range(99) < 40, $urandom,
                $urandom_range(99) < 60, $urandom_range(99) < 5, $urandom_range(99) >= 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
